tff_toggle_arbiter: RTL

// - Owns a bank of NUM_TFF synchronous-reset T flip-flops. Shares toggle access among NUM_REQ requesters.
// - Round-robin arbiter: grants one toggle request per cycle over a valid/ready handshake.
// - Sits between control agents (mode/flag toggles) and the status-flag bank. The q outputs feed downstream logic.

---
 rtl/tff_toggle_arbiter_if.sv | 16 +
 rtl/tff_toggle_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/tff_toggle_arbiter_if.sv
// Toggle-request bus between control agents and the T flip-flop bank.
// Handshake: a requester raises req_valid[r] with req_idx slice r and holds
// both stable until it sees req_ready[r]; a transfer happens on any rising
// edge where req_valid[r] & req_ready[r]. Dropping valid before ready simply
// withdraws the request. req_ready is combinational and at most one-hot.
interface tff_toggle_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_idx;
  logic [NUM_REQ-1:0]       req_ready;

  modport master (output req_valid, output req_idx, input req_ready);
  modport slave  (input req_valid, input req_idx, output req_ready);
endinterface

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbitrated bank of T flip-flops. One toggle per cycle at most.
// Optional macro TOGGLE_CNT_EN adds a saturating count of applied toggles;
// without it o_tog_cnt is tied to zero. o_rr_ptr exposes the arbiter pointer.
module tff_toggle_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_TFF = 8,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  tff_toggle_arbiter_if.slave req_if,
  output logic [NUM_TFF-1:0]  o_q,
  output logic                o_grant_vld,
  output logic [2:0]          o_grant_id,
  output logic                o_err_oor,
  output logic [CNT_W-1:0]    o_tog_cnt,
  output logic [2:0]          o_rr_ptr
);
  localparam logic [31:0] NUM_TFF_U = NUM_TFF;

  logic [2:0]           r_rr_ptr;
  logic [NUM_TFF-1:0]   r_q;
  logic                 r_grant_vld;
  logic [2:0]           r_grant_id;
  logic                 r_err_oor;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_any;
  logic [3:0]           w_sum;
  logic [2:0]           w_winner;
  logic [2:0]           w_next_ptr;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_oor;
  logic                 w_xfer;
  logic [NUM_TFF-1:0]   w_tog_mask;

  // Rotate the request vector so rr_ptr sits at bit 0, then take the first set bit.
  always_comb begin
    w_dbl = {req_if.req_valid, req_if.req_valid};
    w_rot = w_dbl >> r_rr_ptr;
    w_any = 1'b0;
    w_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_rr_ptr} + 4'(k);
      end
    end
    if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
    w_winner   = w_sum[2:0];
    w_next_ptr = (w_winner == 3'(NUM_REQ - 1)) ? 3'd0 : w_winner + 3'd1;
  end

  // Grant, target decode and toggle mask; rst and clr suppress any grant.
  always_comb begin
    w_xfer           = w_any & ~rst & ~i_clr;
    req_if.req_ready = '0;
    w_sel_idx        = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_winner == 3'(r)) begin
        req_if.req_ready[r] = w_xfer;
        w_sel_idx           = req_if.req_idx[r*IDX_W +: IDX_W];
      end
    end
    w_oor      = 32'(w_sel_idx) >= NUM_TFF_U;
    w_tog_mask = (w_xfer && !w_oor) ? (NUM_TFF'(1) << w_sel_idx) : '0;
  end

  // Bank state: cleared by rst or clr, otherwise one bit flips per in-range transfer.
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_q <= '0;
    else              r_q <= r_q ^ w_tog_mask;
  end

  // Round-robin pointer moves past the winner only on a transfer.
  always_ff @(posedge clk) begin
    if (rst)         r_rr_ptr <= '0;
    else if (w_xfer) r_rr_ptr <= w_next_ptr;
  end

  // Registered status of the previous cycle's transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      r_err_oor   <= 1'b0;
    end else begin
      r_grant_vld <= w_xfer;
      r_err_oor   <= w_xfer & w_oor;
      if (w_xfer) r_grant_id <= w_winner;
    end
  end

`ifdef TOGGLE_CNT_EN
  logic [CNT_W-1:0] r_tog_cnt;

  // Saturating count of toggles actually applied to the bank.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_tog_cnt <= '0;
    else if (w_xfer && !w_oor && (r_tog_cnt != {CNT_W{1'b1}}))
      r_tog_cnt <= r_tog_cnt + CNT_W'(1);
  end

  assign o_tog_cnt = r_tog_cnt;
`else
  assign o_tog_cnt = '0;
`endif

  assign o_q         = r_q;
  assign o_grant_vld = r_grant_vld;
  assign o_grant_id  = r_grant_id;
  assign o_err_oor   = r_err_oor;
  assign o_rr_ptr    = r_rr_ptr;
endmodule
